// File: rtl/mem_pkg.sv
// Memory op codes and decode helpers. The core, the memory model and the
// access arbiter all import this package.
package mem_pkg;

    localparam int unsigned OP_W = 8;

    typedef logic [OP_W-1:0] mem_op_t;

    localparam mem_op_t MEM_ERROR   = 8'd0;
    localparam mem_op_t LOAD_BYTE   = 8'd1;
    localparam mem_op_t LOAD_HALF   = 8'd2;
    localparam mem_op_t LOAD_WORD   = 8'd3;
    localparam mem_op_t LOAD_BYTE_U = 8'd4;
    localparam mem_op_t LOAD_HALF_U = 8'd5;
    localparam mem_op_t STORE_BYTE  = 8'd6;
    localparam mem_op_t STORE_HALF  = 8'd7;
    localparam mem_op_t STORE_WORD  = 8'd8;

    function automatic logic is_legal_op(input mem_op_t op);
        case (op)
            LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_U, LOAD_HALF_U,
            STORE_BYTE, STORE_HALF, STORE_WORD: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input mem_op_t op);
        case (op)
            LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_U, LOAD_HALF_U: return 1'b1;
            default:                                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        case (req)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between two requesters: round-robin grant,
// fixed-latency hold of the memory inputs, then a one-cycle completion pulse.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [OP_W-1:0]   p0_op,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [OP_W-1:0]   p1_op,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [OP_W-1:0]   mem_op,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam int unsigned    CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              arb_gnt, arb_valid;
    logic              grant, finish, sel_legal;
    logic [OP_W-1:0]   sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req   ({p1_req, p0_req}),
        .last  (last),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // Next state plus the grant/finish strobes that steer the datapath.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        finish     = 1'b0;
        sel_op     = arb_gnt ? p1_op    : p0_op;
        sel_addr   = arb_gnt ? p1_addr  : p0_addr;
        sel_wdata  = arb_gnt ? p1_wdata : p0_wdata;
        sel_legal  = is_legal_op(sel_op);
        case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    grant      = 1'b1;
                    state_next = sel_legal ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                if (cnt == CNT_LAST) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            owner       <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_op      <= MEM_ERROR;
            mem_data_in <= '0;
            p0_done     <= 1'b0;
            p0_err      <= 1'b0;
            p0_rdata    <= '0;
            p1_done     <= 1'b0;
            p1_err      <= 1'b0;
            p1_rdata    <= '0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != S_IDLE);
            cnt     <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
            p0_done <= 1'b0;
            p0_err  <= 1'b0;
            p1_done <= 1'b0;
            p1_err  <= 1'b0;

            // An illegal op never touches the memory and completes right away.
            if (grant) begin
                owner <= arb_gnt;
                last  <= arb_gnt;
                cnt   <= '0;
                if (sel_legal) begin
                    mem_addr    <= sel_addr;
                    mem_op      <= sel_op;
                    mem_data_in <= sel_wdata;
                end else if (arb_gnt) begin
                    p1_done  <= 1'b1;
                    p1_err   <= 1'b1;
                    p1_rdata <= '0;
                end else begin
                    p0_done  <= 1'b1;
                    p0_err   <= 1'b1;
                    p0_rdata <= '0;
                end
            end

            if (finish) begin
                mem_op <= MEM_ERROR;
                if (owner) begin
                    p1_done  <= 1'b1;
                    p1_rdata <= is_load(mem_op) ? mem_data_out : '0;
                end else begin
                    p0_done  <= 1'b1;
                    p0_rdata <= is_load(mem_op) ? mem_data_out : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized two-requester run against a transaction-schedule model.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int L           = 20;
    localparam int RAND_CYCLES = 3000;
    localparam int NVEC        = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [7:0]  p0_op, p1_op;
    logic        p0_done, p1_done, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic [7:0]  mem_op;
    logic        busy, owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_op(p0_op), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_op(p1_op), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_op(mem_op), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .busy(busy), .owner(owner)
    );

    // Word-wide stand-in memory: returns whole words, stores write whole words.
    logic [31:0] bench_mem [256];
    assign mem_data_out = bench_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_op inside {8'd6, 8'd7, 8'd8}) bench_mem[mem_addr[9:2]] = mem_data_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input logic [7:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_op = op; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_op = op; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 8'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated access; reports what was seen, indexed from the grant edge.
    task automatic do_txn(input bit port, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output bit err,
                          output int done_idx, output int mem_cycles, output int stray,
                          output logic [31:0] addr_seen, output logic [31:0] wdata_seen);
        bit dn, other;
        @(negedge clk);
        drive(port, 1'b1, op, addr, wdata);
        @(negedge clk);
        drive(port, 1'b0, op, addr, wdata);
        rdata = '0; err = 1'b0; done_idx = -1; mem_cycles = 0; stray = 0;
        addr_seen = '0; wdata_seen = '0;
        for (int i = 0; i < 4 * L; i++) begin
            dn    = port ? p1_done : p0_done;
            other = port ? p0_done : p1_done;
            if (mem_op != 8'd0) begin
                if (mem_cycles == 0) begin
                    addr_seen  = mem_addr;
                    wdata_seen = mem_data_in;
                end
                mem_cycles++;
            end
            if (other) stray++;
            if (dn) begin
                done_idx = i;
                rdata    = port ? p1_rdata : p0_rdata;
                err      = port ? p1_err : p0_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          port;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_done_idx;
        int          exp_mem_cycles;
    } vec_t;

    // Legal ops hold the memory for L cycles and report done L cycles after the grant.
    function automatic vec_t mk(input bit port, input logic [7:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata);
        vec_t v;
        bit   legal;
        legal            = (op >= 8'd1) && (op <= 8'd8);
        v.port           = port;
        v.op             = op;
        v.addr           = addr;
        v.wdata          = wdata;
        v.exp_rdata      = rdata;
        v.exp_err        = !legal;
        v.exp_done_idx   = legal ? L : 0;
        v.exp_mem_cycles = legal ? L : 0;
        return v;
    endfunction

    function automatic logic [7:0] rand_op();
        int unsigned sel;
        sel = $urandom_range(9, 0);
        if (sel == 0) return 8'd0;
        if (sel == 1) return 8'($urandom_range(255, 9));
        return 8'($urandom_range(8, 1));
    endfunction

    // Reference model: whole-transaction schedule (grant edge g, done edge d).
    bit          m_active, m_owner, m_last, m_legal;
    int          m_g, m_d, t;
    logic [7:0]  m_op;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata [2];
    logic [31:0] ref_mem [256];
    bit          exp_busy;
    bit          exp_done [2];
    bit          exp_err [2];
    logic [7:0]  exp_mop;
    int          gap [2];

    task automatic model_step();
        bit r0, r1, w;
        r0 = p0_req;
        r1 = p1_req;
        if ((!m_active || t >= m_d + 2) && (r0 || r1)) begin
            w        = (r0 && r1) ? !m_last : r1;
            m_last   = w;
            m_owner  = w;
            m_active = 1'b1;
            m_g      = t;
            m_op     = w ? p1_op : p0_op;
            m_addr   = w ? p1_addr : p0_addr;
            m_wdata  = w ? p1_wdata : p0_wdata;
            m_legal  = (m_op >= 8'd1) && (m_op <= 8'd8);
            m_d      = m_legal ? t + L : t;
        end
        exp_busy    = m_active && t >= m_g && t <= m_d;
        exp_mop     = (m_active && m_legal && t >= m_g && t < m_g + L) ? m_op : 8'd0;
        exp_done[0] = 1'b0; exp_done[1] = 1'b0;
        exp_err[0]  = 1'b0; exp_err[1]  = 1'b0;
        if (m_active && t == m_d) begin
            exp_done[m_owner] = 1'b1;
            exp_err[m_owner]  = !m_legal;
            if (m_legal && m_op <= 8'd5) m_rdata[m_owner] = ref_mem[m_addr[9:2]];
            else                         m_rdata[m_owner] = 32'd0;
            if (m_legal && m_op > 8'd5) ref_mem[m_addr[9:2]] = m_wdata;
        end
    endtask

    vec_t        vecs [NVEC];
    logic [31:0] w4000;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, as, ws, a4000;
        bit          er;
        int          di, mc, st;

        a4000 = 32'd4000;
        w4000 = 32'h0050_0093;
        for (int i = 0; i < 256; i++) bench_mem[i] = 32'hC0DE_0000 | 32'(i);
        bench_mem[a4000[9:2]] = w4000;

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 8'd0, 32'd0, 32'd0);
        do_reset();

        check("reset busy", 32'(busy), 32'd0);
        check("reset owner", 32'(owner), 32'd0);
        check("reset mem_op", 32'(mem_op), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_data_in", mem_data_in, 32'd0);
        check("reset p0_done", 32'(p0_done), 32'd0);
        check("reset p1_done", 32'(p1_done), 32'd0);
        check("reset p0_err", 32'(p0_err), 32'd0);
        check("reset p1_err", 32'(p1_err), 32'd0);
        check("reset p0_rdata", p0_rdata, 32'd0);
        check("reset p1_rdata", p1_rdata, 32'd0);

        // Tie after reset with both requests held: p0, p1, p0 with one IDLE between.
        drive(1'b0, 1'b1, LOAD_WORD, 32'd4000, 32'd0);
        drive(1'b1, 1'b1, LOAD_WORD, 32'h100, 32'd0);
        for (int i = 0; i <= 2 * L + 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("tie1 owner", 32'(owner), 32'd0);
                check("tie1 busy", 32'(busy), 32'd1);
            end
            if (i == L) begin
                check("tie1 p0_done", 32'(p0_done), 32'd1);
                check("tie1 p0_rdata", p0_rdata, w4000);
            end
            if (i == L + 1) check("tie gap1 busy", 32'(busy), 32'd0);
            if (i == L + 2) begin
                check("tie2 owner", 32'(owner), 32'd1);
                check("tie2 busy", 32'(busy), 32'd1);
            end
            if (i == 2 * L + 2) begin
                check("tie2 p1_done", 32'(p1_done), 32'd1);
                check("tie2 p1_rdata", p1_rdata, 32'hC0DE_0040);
            end
            if (i == 2 * L + 3) check("tie gap2 busy", 32'(busy), 32'd0);
            if (i == 2 * L + 4) begin
                check("tie3 owner", 32'(owner), 32'd0);
                check("tie3 busy", 32'(busy), 32'd1);
            end
        end
        do_reset();

        vecs[0]  = mk(1'b0, LOAD_WORD,   32'd4000, 32'd0,         w4000);
        vecs[1]  = mk(1'b1, STORE_WORD,  32'h100,  32'hDEAD_BEEF, 32'd0);
        vecs[2]  = mk(1'b1, LOAD_WORD,   32'h100,  32'd0,         32'hDEAD_BEEF);
        vecs[3]  = mk(1'b1, 8'h0C,       32'h100,  32'd0,         32'd0);
        vecs[4]  = mk(1'b0, LOAD_BYTE_U, 32'd4000, 32'd0,         w4000);
        vecs[5]  = mk(1'b0, MEM_ERROR,   32'h200,  32'd0,         32'd0);
        vecs[6]  = mk(1'b1, STORE_BYTE,  32'h100,  32'h0000_00AA, 32'd0);
        vecs[7]  = mk(1'b1, LOAD_HALF,   32'h100,  32'd0,         32'h0000_00AA);
        vecs[8]  = mk(1'b0, STORE_HALF,  32'h3FC,  32'h0000_1234, 32'd0);
        vecs[9]  = mk(1'b0, LOAD_WORD,   32'h3FC,  32'd0,         32'h0000_1234);
        vecs[10] = mk(1'b0, 8'd9,        32'h3FC,  32'd0,         32'd0);
        vecs[11] = mk(1'b0, LOAD_HALF_U, 32'h100,  32'd0,         32'h0000_00AA);

        for (int i = 0; i < NVEC; i++) begin
            do_txn(vecs[i].port, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                   rd, er, di, mc, st, as, ws);
            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d done_cycle", i), 32'(di), 32'(vecs[i].exp_done_idx));
            check($sformatf("v%0d mem_cycles", i), 32'(mc), 32'(vecs[i].exp_mem_cycles));
            check($sformatf("v%0d other_done", i), 32'(st), 32'd0);
            if (!vecs[i].exp_err) begin
                check($sformatf("v%0d mem_addr", i), as, vecs[i].addr);
                check($sformatf("v%0d mem_data_in", i), ws, vecs[i].wdata);
            end
        end

        // Reset in the middle of a load: aborted silently, next load is clean.
        @(negedge clk);
        drive(1'b0, 1'b1, LOAD_WORD, 32'd4000, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, LOAD_WORD, 32'd4000, 32'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort mem_op", 32'(mem_op), 32'd0);
        check("abort p0_done", 32'(p0_done), 32'd0);
        check("abort p0_rdata", p0_rdata, 32'd0);
        rst = 1'b0;
        st = 0;
        repeat (L + 4) begin
            @(negedge clk);
            if (p0_done) st++;
        end
        check("abort late done", 32'(st), 32'd0);
        do_txn(1'b0, LOAD_WORD, 32'd4000, 32'd0, rd, er, di, mc, st, as, ws);
        check("post-abort rdata", rd, w4000);
        check("post-abort done_cycle", 32'(di), 32'(L));
        check("post-abort err", 32'(er), 32'd0);

        // Randomized two-requester run against the schedule model.
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = bench_mem[i];
        m_active = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_legal = 1'b0;
        m_g = 0; m_d = 0; t = 0;
        m_rdata[0] = 32'd0; m_rdata[1] = 32'd0;
        gap[0] = 0; gap[1] = 0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if (c > 0) begin
                @(negedge clk);
                check($sformatf("rnd t%0d busy", t), 32'(busy), 32'(exp_busy));
                check($sformatf("rnd t%0d owner", t), 32'(owner), 32'(m_owner));
                check($sformatf("rnd t%0d mem_op", t), 32'(mem_op), 32'(exp_mop));
                check($sformatf("rnd t%0d p0_done", t), 32'(p0_done), 32'(exp_done[0]));
                check($sformatf("rnd t%0d p1_done", t), 32'(p1_done), 32'(exp_done[1]));
                check($sformatf("rnd t%0d p0_err", t), 32'(p0_err), 32'(exp_err[0]));
                check($sformatf("rnd t%0d p1_err", t), 32'(p1_err), 32'(exp_err[1]));
                check($sformatf("rnd t%0d p0_rdata", t), p0_rdata, m_rdata[0]);
                check($sformatf("rnd t%0d p1_rdata", t), p1_rdata, m_rdata[1]);
            end
            for (int p = 0; p < 2; p++) begin
                bit r, dn;
                r  = (p == 1) ? p1_req : p0_req;
                dn = (p == 1) ? p1_done : p0_done;
                if (r && dn) begin
                    if (($urandom & 1) == 0) begin
                        drive(1'(p), 1'b0, 8'd0, 32'd0, 32'd0);
                        gap[p] = int'($urandom_range(4, 0));
                    end else begin
                        drive(1'(p), 1'b1, rand_op(), $urandom & 32'h3FC, $urandom);
                    end
                end else if (!r) begin
                    if (gap[p] == 0) drive(1'(p), 1'b1, rand_op(), $urandom & 32'h3FC, $urandom);
                    else gap[p]--;
                end
            end
            model_step();
            @(posedge clk);
            t++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
